// File: rtl/wb_bus_arbiter_if.sv
// rtl/wb_bus_arbiter_if.sv - Wishbone bus bundle with burst-length flags
//
// One Wishbone port as seen between a bus master and a bus slave.
//   master modport: drives cyc/stb/we/adr/o_dat/sel/8_burst/4_burst, receives i_dat/ack/err
//   slave modport : the mirror image
interface wb_bus_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic              wb_cyc;
    logic              wb_stb;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_adr;
    logic [DATA_W-1:0] wb_o_dat;
    logic [1:0]        wb_sel;
    logic              wb_8_burst;
    logic              wb_4_burst;
    logic [DATA_W-1:0] wb_i_dat;
    logic              wb_ack;
    logic              wb_err;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel, wb_8_burst, wb_4_burst,
        input  wb_i_dat, wb_ack, wb_err
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel, wb_8_burst, wb_4_burst,
        output wb_i_dat, wb_ack, wb_err
    );
endinterface

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - two-master round-robin Wishbone arbiter with burst hold and watchdog
//
// Shares one slave-side Wishbone bus between m0 (instruction fetch) and m1 (load/store).
//   clk, rst_n : clock, asynchronous active-low reset
//   m0, m1     : master-facing ports (slave modport); read data is broadcast to both,
//                ack/err go only to the granted master
//   s          : slave-facing port (master modport), muxed from the granted master
//   TIMEOUT_W  : watchdog width; a strobe left unterminated for 2^TIMEOUT_W-1 cycles
//                is ended with an err pulse
module wb_bus_arbiter #(
    parameter int TIMEOUT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_bus_arbiter_if.slave    m0,
    wb_bus_arbiter_if.slave    m1,
    wb_bus_arbiter_if.master   s
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 last_q, last_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 tmo_hold_q, tmo_hold_d;

    logic        req0, req1;
    logic        gnt0, gnt1;
    logic        own_cyc, own_stb, own_we, own_b8, own_b4;
    logic [23:0] own_adr;
    logic [15:0] own_dat;
    logic [1:0]  own_sel;
    logic        stb_eff;
    logic        tmo_pulse;
    logic        route_ack, route_err;
    logic        term;
    logic        load;
    logic [3:0]  load_val;

    assign req0 = m0.wb_cyc & m0.wb_stb;
    assign req1 = m1.wb_cyc & m1.wb_stb;
    assign gnt0 = (state_q == ST_GNT0);
    assign gnt1 = (state_q == ST_GNT1);

    // Owner mux; everything reads as zero while idle, so the slave bus is quiet
    // the instant reset forces the state back to IDLE.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_b8  = 1'b0;
        own_b4  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        if (gnt0) begin
            own_cyc = m0.wb_cyc;
            own_stb = m0.wb_stb;
            own_we  = m0.wb_we;
            own_b8  = m0.wb_8_burst;
            own_b4  = m0.wb_4_burst;
            own_adr = m0.wb_adr;
            own_dat = m0.wb_o_dat;
            own_sel = m0.wb_sel;
        end else if (gnt1) begin
            own_cyc = m1.wb_cyc;
            own_stb = m1.wb_stb;
            own_we  = m1.wb_we;
            own_b8  = m1.wb_8_burst;
            own_b4  = m1.wb_4_burst;
            own_adr = m1.wb_adr;
            own_dat = m1.wb_o_dat;
            own_sel = m1.wb_sel;
        end
    end

    assign stb_eff = own_stb & ~tmo_hold_q;

    // The watchdog only fires when the slave did not terminate in the same cycle,
    // so a beat is never ended twice.
    assign tmo_pulse = stb_eff & (&wd_q) & ~s.wb_ack & ~s.wb_err;

    // Terminations reach a master only while it still holds cyc; acks arriving
    // after an abort are dropped.
    assign route_ack = own_cyc & s.wb_ack;
    assign route_err = own_cyc & (s.wb_err | tmo_pulse);

    assign s.wb_cyc     = own_cyc;
    assign s.wb_stb     = stb_eff;
    assign s.wb_we      = own_we;
    assign s.wb_adr     = own_adr;
    assign s.wb_o_dat   = own_dat;
    assign s.wb_sel     = own_sel;
    assign s.wb_8_burst = own_b8;
    assign s.wb_4_burst = own_b4;

    assign m0.wb_i_dat = s.wb_i_dat;
    assign m1.wb_i_dat = s.wb_i_dat;
    assign m0.wb_ack   = gnt0 & route_ack;
    assign m0.wb_err   = gnt0 & route_err;
    assign m1.wb_ack   = gnt1 & route_ack;
    assign m1.wb_err   = gnt1 & route_err;

    assign term     = route_ack | route_err;
    assign load     = stb_eff & (bcnt_q == 4'd0);
    assign load_val = own_we ? 4'd1 : (own_b8 ? 4'd8 : (own_b4 ? 4'd4 : 4'd1));

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        bcnt_d     = bcnt_q;
        wd_d       = wd_q;
        tmo_hold_d = tmo_hold_q;

        unique case (state_q)
            ST_IDLE: begin
                // On a tie the master that was not served last wins.
                if (req0 && (!req1 || last_q)) begin
                    state_d = ST_GNT0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = ST_GNT1;
                    last_d  = 1'b1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_IDLE || !own_cyc || tmo_pulse) begin
            bcnt_d = 4'd0;
        end else if (load) begin
            bcnt_d = term ? (load_val - 4'd1) : load_val;
        end else if (term && bcnt_q != 4'd0) begin
            bcnt_d = bcnt_q - 4'd1;
        end

        if (!stb_eff || s.wb_ack || s.wb_err || tmo_pulse) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end

        // Hold the strobe off after a timeout until the master lets go of it.
        if (state_q == ST_IDLE) begin
            tmo_hold_d = 1'b0;
        end else if (tmo_pulse) begin
            tmo_hold_d = 1'b1;
        end else if (!own_cyc || !own_stb) begin
            tmo_hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            bcnt_q     <= 4'd0;
            wd_q       <= '0;
            tmo_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            bcnt_q     <= bcnt_d;
            wd_q       <= wd_d;
            tmo_hold_q <= tmo_hold_d;
        end
    end

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Single-clock Wishbone arbiter that shares one slave-side bus between two masters (m0: instruction fetch, m1: data/load-store). It sits between the core's memory ports and the clock-crossing bridge or peripheral interconnect. Arbitration is round-robin per bus cycle, and a granted master keeps the bus for the whole read burst (4 or 8 beats). A watchdog terminates transfers that never receive ack or err.

## Interface
- TIMEOUT_W, 8: watchdog counter width; timeout fires after 2^TIMEOUT_W−1 cycles with no ack/err.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mN_wb_cyc, mN_wb_stb, mN_wb_we  in  1 each (N=0,1)  master N bus cycle / strobe / write enable.
- mN_wb_adr  in  `WB_ADDR_W` (24)  master N address.
- mN_wb_o_dat  in  `RW` (16)  master N write data.
- mN_wb_sel  in  2  master N byte select.
- mN_wb_8_burst, mN_wb_4_burst  in  1 each  master N read burst length request.
- mN_wb_i_dat  out  16  read data; both masters are driven from s_wb_i_dat.
- mN_wb_ack, mN_wb_err  out  1 each  routed to the granted master only.
- s_wb_cyc, s_wb_stb, s_wb_we  out  1 each  slave-side bus.
- s_wb_adr  out  24  slave-side address.
- s_wb_o_dat  out  16  slave-side write data.
- s_wb_sel  out  2  slave-side byte select.
- s_wb_8_burst, s_wb_4_burst  out  1 each  slave-side burst flags.
- s_wb_i_dat  in  16  slave read data.
- s_wb_ack, s_wb_err  in  1 each  slave termination.

## Operation
- State machine states:
  - IDLE: no grant.
  - GNT0: m0 owns the bus.
  - GNT1: m1 owns the bus.
- `last` register holds the last granted master.
- Request: `reqN = mN_wb_cyc & mN_wb_stb`.
- IDLE transitions:
  - Only req0: go to GNT0.
  - Only req1: go to GNT1.
  - Both: grant the master other than `last`. `last` resets to 1, so m0 wins the first tie.
  - On any grant, `last` is updated to the granted master.
- GNTx outputs:
  - All s_wb_* outputs are combinationally muxed from master x.
  - s_wb_stb = mx_wb_stb & ~tmo_hold.
  - mx_wb_ack = s_wb_ack; mx_wb_err = s_wb_err | tmo_pulse.
  - The non-granted master sees ack=0 and err=0.
- IDLE outputs: every s_wb_* output is 0, and both masters see ack=0 and err=0.
- Burst counter `bcnt` (4 bits):
  - Load on a strobed slave cycle with bcnt==0:
    - Read (we=0): load 8 if 8_burst, else 4 if 4_burst, else 1.
    - Write (we=1): always load 1.
  - Decrement on each ack, err or tmo_pulse.
  - If load and termination occur in the same cycle, load N−1.
- Release: GNTx returns to IDLE on the cycle after mx_wb_cyc is sampled low.
- Abort: if cyc drops while bcnt≠0, clear bcnt, release, and ignore any late slave acks; they are not routed to either master.
- Grant changes only through IDLE, so there is one dead cycle between owners. A master is never switched mid-burst.
- Watchdog `wd`:
  - Clears on any ack/err, or when s_wb_stb=0.
  - Otherwise increments while s_wb_stb=1.
  - At all-ones: one-cycle tmo_pulse to the granted master, bcnt cleared, then tmo_hold=1, which forces s_wb_stb=0 until the master drops stb or cyc.
- Reset (rst_n low, any time, including mid-burst):
  - State IDLE, bcnt=0, wd=0, tmo_hold=0, last=1.
  - All outputs 0 immediately (asynchronous); s_wb_i_dat still passes through to mN_wb_i_dat.

## Timing
- Request to slave strobe: 1 cycle. A req sampled at edge k puts s_wb_cyc/stb high after edge k.
- Ack/err/data path slave to master: combinational, 0 cycles.
- Release: cyc low sampled at edge k → IDLE after k; the new grant is visible after edge k+1.
- Back-to-back requests with both masters active alternate m0, m1, m0…, each separated by one IDLE cycle.
- 8-beat read: grant held for at least 8 acks. bcnt==0 exactly after the 8th ack.
- Timeout: tmo_pulse asserts in the cycle wd reaches 2^TIMEOUT_W−1 (255 at default), counted from the first unacknowledged strobe.

## Test plan
- After reset, only m0 requests a single read at 0x000100 → s_wb_adr=0x000100 one cycle later. The slave acks with 0xBEEF: m0 sees ack and data 0xBEEF, m1_wb_ack=0.
- Both masters request in the same cycle after reset → m0 is granted first. After m0 drops cyc, m1 is granted one IDLE cycle later. Another simultaneous request → m0 is granted.
- m1 issues an 8_burst read while m0 requests continuously → m1 receives exactly 8 acks before m0 gets s_wb_cyc. bcnt goes 8→0.
- Write with 8_burst=1 → bcnt loads 1, and the grant is released when cyc falls after the single ack.
- Slave never acks, TIMEOUT_W=4 → m0_wb_err pulses exactly at cycle 15 of the strobe, then s_wb_stb=0 until m0 drops stb.
- rst_n asserted mid-4-beat burst after 2 acks → all outputs 0 immediately. After release, a fresh m1 request is granted normally with bcnt=0.
